// File: rtl/security_alert_ctrl.sv
// security_alert_ctrl: arm/entry-delay/alarm FSM with latched, escalating notification channels.
// Optional macro TAMPER_EN adds a tamper input that forces an immediate full alarm.
module security_alert_ctrl #(
  parameter int N_SRC     = 4,
  parameter int N_CH      = 3,
  parameter int ENTRY_DLY = 16,
  parameter int ESC_STEP  = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             ack,
`ifdef TAMPER_EN
  input  logic             tamper,
`endif
  output logic [N_CH-1:0]  alert_out,
  output logic             armed,
  output logic [1:0]       state,
  output logic [N_SRC-1:0] src_latched
);
  typedef enum logic [1:0] {DISARMED, ARMED, PENDING, ALARM} state_e;
  localparam logic [CNT_W-1:0] ESC_MAX = CNT_W'((N_CH - 1) * ESC_STEP);
  localparam logic [CNT_W-1:0] DLY     = CNT_W'(ENTRY_DLY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]    alert_q, alert_d, esc_hit;
  logic [N_SRC-1:0]   lat_q, lat_d, hits;
  logic               armed_q, armed_d, trig;
  assign hits = src_in & ~src_mask;
  assign trig = |hits;
  always_comb begin
    for (int k = 0; k < N_CH; k++) esc_hit[k] = cnt_q >= CNT_W'(k * ESC_STEP);
  end
  // Alerts are registered from the ALARM state, so alert_out[0] lags state by one edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alert_d = alert_q;
    lat_d   = lat_q;
    case (state_q)
      DISARMED: if (arm) begin
        state_d = ARMED;
        lat_d   = '0;
      end
      ARMED: if (!arm) state_d = DISARMED;
        else if (trig) begin
          lat_d   = lat_q | hits;
          state_d = (ENTRY_DLY > 0) ? PENDING : ALARM;
          cnt_d   = (ENTRY_DLY > 0) ? DLY : '0;
        end
      PENDING: if (!arm) begin
        state_d = DISARMED;
        lat_d   = '0;
        cnt_d   = '0;
      end else begin
        lat_d   = lat_q | hits;
        state_d = (cnt_q == ONE) ? ALARM : PENDING;
        cnt_d   = (cnt_q == ONE) ? '0 : cnt_q - ONE;
      end
      ALARM: if (ack) begin
        state_d = arm ? ARMED : DISARMED;
        alert_d = '0;
        lat_d   = '0;
        cnt_d   = '0;
      end else begin
        lat_d   = lat_q | hits;
        alert_d = alert_q | esc_hit;
        cnt_d   = (cnt_q < ESC_MAX) ? cnt_q + ONE : ESC_MAX;
      end
      default: state_d = DISARMED;
    endcase
`ifdef TAMPER_EN
    if (tamper) begin
      state_d = ALARM;
      alert_d = '1;
      lat_d   = lat_q | hits;
      cnt_d   = ESC_MAX;
    end
`endif
    armed_d = state_d != DISARMED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISARMED;
      cnt_q   <= '0;
      alert_q <= '0;
      lat_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
      lat_q   <= lat_d;
      armed_q <= armed_d;
    end
  end
  assign alert_out   = alert_q;
  assign armed       = armed_q;
  assign state       = state_q;
  assign src_latched = lat_q;
endmodule

// File: tb/tb_security_alert_ctrl.sv
// tb_security_alert_ctrl: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_security_alert_ctrl;
  logic       clk = 0, rst = 0, arm = 0, ack = 0;
  logic [3:0] src_in = 0, src_mask = 0;
  logic [2:0] alert_out;
  logic       armed;
  logic [1:0] state;
  logic [3:0] src_latched;
`ifdef TAMPER_EN
  logic       tamper = 0;
`endif
  security_alert_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .src_in(src_in), .src_mask(src_mask), .ack(ack),
`ifdef TAMPER_EN
    .tamper(tamper),
`endif
    .alert_out(alert_out), .armed(armed), .state(state), .src_latched(src_latched)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0] st;
    logic [2:0] al;
    logic [3:0] lat;
    logic [7:0] tag;
  } exp_t;
  exp_t       q[$];
  exp_t       e;
  int         checks = 0, failures = 0;
  logic [7:0] tag = 0;
  always @(posedge clk or posedge rst) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, armed, alert_out, src_latched} !== {e.st, e.st != 2'd0, e.al, e.lat}) begin
        failures++;
        $display("FAIL p%0d got st=%0d armed=%0b al=%b lat=%b want st=%0d armed=%0b al=%b lat=%b",
                 e.tag, state, armed, alert_out, src_latched, e.st, e.st != 2'd0, e.al, e.lat);
      end
    end
  end
  task automatic push(input logic [1:0] st, input logic [2:0] al, input logic [3:0] lat);
    q.push_back('{st, al, lat, tag});
  endtask
  task automatic cyc(input logic a, input logic [3:0] s, input logic k,
                     input logic [1:0] st, input logic [2:0] al, input logic [3:0] lat);
    arm = a; src_in = s; ack = k;
    @(posedge clk);
    push(st, al, lat);
    @(negedge clk);
  endtask
  task automatic reset_pulse();
    rst = 1;
    push(0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
  endtask
  function automatic logic [2:0] esc(input int j);
    return (j >= 33) ? 3'b111 : (j >= 25) ? 3'b011 : 3'b001;
  endfunction
  initial begin
    @(negedge clk);
    tag = 1;
    reset_pulse();
    for (int i = 0; i < 20; i++) cyc(0, 4'hF, 0, 0, 0, 0);
    tag = 2;
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 4'b0010, 0, 2, 0, 4'b0010);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 2, 0, 4'b0010);
    cyc(1, 0, 0, 3, 0, 4'b0010);
    for (int j = 17; j <= 40; j++) cyc(1, 0, 0, 3, esc(j), 4'b0010);
    tag = 3;
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    tag = 4;
    cyc(1, 4'b0001, 0, 2, 0, 4'b0001);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 2, 0, 4'b0001);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    tag = 5;
    src_mask = 4'b0001;
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 4'b0001, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 4'b1000, 0, 2, 0, 4'b1000);
    cyc(1, 4'b0100, 0, 2, 0, 4'b1100);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 2, 0, 4'b1100);
    cyc(1, 0, 0, 3, 0, 4'b1100);
    for (int j = 17; j <= 34; j++) cyc(j < 26, 0, 0, 3, esc(j), 4'b1100);
    tag = 6;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    src_mask = 0;
    tag = 7;
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 4'b0010, 0, 2, 0, 4'b0010);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 2, 0, 4'b0010);
    cyc(1, 0, 0, 3, 0, 4'b0010);
    cyc(1, 0, 0, 3, 3'b001, 4'b0010);
    cyc(1, 4'b0100, 1, 1, 0, 0);
    cyc(1, 4'b0100, 0, 2, 0, 4'b0100);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 4'b1000, 0, 0, 0, 0);
    tag = 8;
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 4'b0001, 0, 2, 0, 4'b0001);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 2, 0, 4'b0001);
    cyc(1, 0, 0, 3, 0, 4'b0001);
    cyc(1, 0, 0, 3, 3'b001, 4'b0001);
    reset_pulse();
    cyc(0, 0, 0, 0, 0, 0);
`ifdef TAMPER_EN
    tag = 9;
    tamper = 1;
    cyc(0, 0, 0, 3, 3'b111, 0);
    cyc(0, 0, 1, 3, 3'b111, 0);
    tamper = 0;
    cyc(0, 0, 0, 3, 3'b111, 0);
    cyc(0, 0, 1, 0, 0, 0);
`endif
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
